hilo_divider: RTL and testbench
===============================

# hilo_divider

Multi-cycle signed 32-bit divider with HI/LO result registers. It sits directly downstream of the control unit and consumes its `is_div`, `mf` and `lo_or_hi` decode outputs. It stalls the single-cycle datapath (freezes the PC and register writes) while a `div` executes. It also supplies the HI/LO value selected by `mfhi`/`mflo` to the register write-back mux.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `is_div`  in  1  decoded `div` (R-type, funct 0x1A) from the control unit.
- `mf`  in  1  decoded `mfhi`/`mflo` from the control unit.
- `lo_or_hi`  in  1  funct[1]; 1 selects LO (`mflo`), 0 selects HI (`mfhi`).
- `rs_data`  in  32  dividend (register file port 1).
- `rt_data`  in  32  divisor (register file port 2).
- `stall`  out  1  freeze PC and all architectural writes this cycle.
- `hilo_out`  out  32  `lo_or_hi ? LO : HI`, combinational from registers.
- `done`  out  1  one-cycle pulse in the cycle the `div` retires.
- `div_by_zero`  out  1  one-cycle pulse coincident with `done` when the divisor was 0.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- **IDLE**
  - `stall = is_div`.
  - On `is_div`, capture `|rs|`, `|rt|`, the sign of `rs` and `sign(rs)^sign(rt)`.
  - Load the iteration counter with 31 and clear the partial remainder.
  - Go to BUSY, or to FIX if `rt_data == 0`.
- **BUSY**
  - `stall = 1`.
  - One restoring-division step per cycle (shift, trial-subtract, set quotient bit).
  - Counter decrements; when it reaches 0, go to FIX. That is 32 BUSY cycles.
- **FIX**
  - `stall = 1`.
  - Normal case, written at the exit edge:
    - LO = quotient, negated if the sign-xor flag is set.
    - HI = remainder, negated if the dividend was negative.
  - Divide by zero, written at the exit edge: LO = 0xFFFFFFFF, HI = captured `rs_data`.
  - Go to DONE.
- **DONE**
  - `stall = 0`, `done = 1`, `div_by_zero` = the flag latched from divide-by-zero detection.
  - The `div` instruction retires this cycle.
  - `is_div` is still high here because the same instruction is present; it must be ignored.
  - Go to IDLE unconditionally.
- **Arithmetic**
  - Magnitudes are held in 32-bit unsigned form; |0x80000000| = 0x80000000 is handled without overflow.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps; no trap).
- **`mf`**
  - Purely combinational read; `hilo_out` is valid in every state.
  - An `mf` cannot coincide with BUSY/FIX because the PC is frozen.
  - `stall` does not depend on `mf`.
- HI/LO change only at the FIX exit edge and on reset.

## Timing
- **Reset**
  - State = IDLE; HI = LO = 0; counter = 0; flags cleared.
  - `stall`, `done` and `div_by_zero` are all 0 while `reset` is high.
  - `hilo_out` = 0 after the first reset edge.
- **Normal `div`**
  - `stall` is high for 34 consecutive cycles: 1 IDLE + 32 BUSY + 1 FIX.
  - `done` is high on cycle 35.
  - The new HI/LO are visible on `hilo_out` from cycle 35.
- **Divide by zero**
  - `stall` is high for 2 cycles (IDLE, FIX); `done` and `div_by_zero` are high on cycle 3.
- **Back-to-back `div`**
  - The second `is_div` is accepted in the cycle after DONE.
  - No `div` is accepted in DONE.
- **Reset mid-operation**
  - Any state goes to IDLE at the reset edge.
  - The in-flight result is discarded and HI/LO are cleared to 0.
  - No `done` pulse.
- Operands are sampled only at the IDLE→BUSY/FIX edge. Changes on `rs_data`/`rt_data` afterwards have no effect.

## Test plan
- rs = 100, rt = 7 -> `stall` high for exactly 34 cycles; `done` on cycle 35; LO = 14, HI = 2; `hilo_out` = 14 with `lo_or_hi` = 1 and 2 with `lo_or_hi` = 0.
- rs = −7 (0xFFFFFFF9), rt = 2 -> LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1); rs = 7, rt = −2 -> LO = 0xFFFFFFFD, HI = 1.
- rs = 0x80000000, rt = 0xFFFFFFFF -> LO = 0x80000000, HI = 0, 34 stall cycles.
- rs = 5, rt = 0 -> `stall` for 2 cycles; `done` and `div_by_zero` pulse together; LO = 0xFFFFFFFF, HI = 5.
- Assert `reset` on BUSY cycle 10 of 100/7 -> next cycle: IDLE, `stall` = 0, HI = LO = 0, no `done`.
- Hold `is_div` = 1 continuously with rs = 9, rt = 3 -> LO = 3, HI = 0.
  - The DONE cycle does not restart.
  - A new 34-cycle stall begins on the cycle after DONE.
  - `done` pulses are exactly 35 cycles apart.

Source files
------------

// File: rtl/hilo_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_divider_if
// Description : Decode/operand/result bundle between the control unit and
//               the HI/LO divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_divider_if #(
    parameter int WIDTH = 32
);
    logic             is_div;
    logic             mf;
    logic             lo_or_hi;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             stall;
    logic [WIDTH-1:0] hilo_out;
    logic             done;
    logic             div_by_zero;

    // Control unit / register file side
    modport master (
        output is_div, mf, lo_or_hi, rs_data, rt_data,
        input  stall, hilo_out, done, div_by_zero
    );

    // Divider side
    modport slave (
        input  is_div, mf, lo_or_hi, rs_data, rt_data,
        output stall, hilo_out, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
// Module      : hilo_divider
// Description : Multi-cycle signed restoring divider with HI/LO registers.
//               Stalls the datapath while a div executes and serves the
//               mfhi/mflo read path combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic     clock,
    input  wire logic     reset,
    hilo_divider_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_quot;      // holds |rs| on entry, shifts into quotient
    logic [WIDTH-1:0]   r_divisor;   // |rt|
    logic [WIDTH-1:0]   r_rem;       // partial remainder
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_signRs;
    logic               r_signXor;
    logic               r_divZero;

    logic               w_accept;
    logic               w_rtZero;
    logic [WIDTH-1:0]   w_rsMag;
    logic [WIDTH-1:0]   w_rtMag;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic               w_stall;
    logic               w_done;

    // mf is a pure read request; the read mux below does not need it
    wire w_unusedMf = bus.mf;

    // Operand magnitudes; negating 0x80000000 yields 0x80000000, which is the
    // correct unsigned magnitude
    assign w_rsMag  = bus.rs_data[WIDTH-1] ? -bus.rs_data : bus.rs_data;
    assign w_rtMag  = bus.rt_data[WIDTH-1] ? -bus.rt_data : bus.rt_data;
    assign w_rtZero = (bus.rt_data == '0);
    assign w_accept = (r_state == IDLE) && bus.is_div;

    // One restoring step: shift next dividend bit into the remainder and
    // trial-subtract; a clear borrow bit means the divisor fits
    assign w_shifted = {r_rem, r_quot[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};
    assign w_fits    = ~w_diff[WIDTH];

    // Next-state and handshake outputs
    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = bus.is_div;
                if (bus.is_div) begin
                    w_nextState = w_rtZero ? FIX : BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_count == '0) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_stall     = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                // The retiring div still presents is_div here; it is ignored
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_signRs  <= 1'b0;
            r_signXor <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count   <= c_LAST_STEP;
                r_quot    <= w_rsMag;
                r_divisor <= w_rtMag;
                r_rem     <= '0;
                r_signRs  <= bus.rs_data[WIDTH-1];
                r_signXor <= bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1];
                r_divZero <= w_rtZero;
            end
            if (r_state == BUSY) begin
                r_quot  <= {r_quot[WIDTH-2:0], w_fits};
                r_rem   <= w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
                r_count <= r_count - 1'b1;
            end
            if (r_state == FIX) begin
                if (r_divZero) begin
                    // No BUSY steps ran, so r_quot still holds |rs|;
                    // re-applying the sign restores the original rs_data
                    r_lo <= '1;
                    r_hi <= r_signRs ? -r_quot : r_quot;
                end else begin
                    r_lo <= r_signXor ? -r_quot : r_quot;
                    r_hi <= r_signRs  ? -r_rem  : r_rem;
                end
            end
        end
    end

    assign bus.stall       = w_stall & ~reset;
    assign bus.done        = w_done & ~reset;
    assign bus.div_by_zero = w_done & r_divZero & ~reset;
    assign bus.hilo_out    = bus.lo_or_hi ? r_lo : r_hi;

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_divider
// Description : Self-checking bench for hilo_divider; results are checked by
//               a scoreboard monitor on every done pulse, timing per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_divider;
    logic clock = 1'b0;
    logic reset = 1'b0;

    hilo_divider_if #(.WIDTH(32)) bus ();
    hilo_divider #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    int   checks   = 0;
    int   failures = 0;

    // Reference model of signed division with the divider's corner rules
    function automatic exp_t model(input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        if (rt == 32'd0) begin
            e.lo = 32'hFFFF_FFFF; e.hi = rs; e.dz = 1'b1;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'd0; e.dz = 1'b0;
        end else begin
            e.lo = $signed(rs) / $signed(rt);
            e.hi = $signed(rs) % $signed(rt);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_done: done=1 required no pending div");
            end else begin
                monE = sb.pop_front();
                bus.lo_or_hi = 1'b1; #1;
                checks++;
                if (bus.hilo_out !== monE.lo) begin
                    failures++;
                    $display("FAIL sb_lo: got %h required %h", bus.hilo_out, monE.lo);
                end
                bus.lo_or_hi = 1'b0; #1;
                checks++;
                if (bus.hilo_out !== monE.hi) begin
                    failures++;
                    $display("FAIL sb_hi: got %h required %h", bus.hilo_out, monE.hi);
                end
                checks++;
                if (bus.div_by_zero !== monE.dz) begin
                    failures++;
                    $display("FAIL sb_div_by_zero: got %b required %b", bus.div_by_zero, monE.dz);
                end
            end
        end
    end

    // Issues one div holding is_div until retirement; operands are scrambled
    // after the accept edge. Starts and ends 1 time unit after a rising edge.
    task automatic do_div(input logic [31:0] rs, input logic [31:0] rt,
                          output int stallCycles, output int doneCycle, output bit stallGap);
        stallCycles = 0; doneCycle = 0; stallGap = 1'b0;
        sb.push_back(model(rs, rt));
        bus.rs_data = rs; bus.rt_data = rt; bus.is_div = 1'b1;
        for (int cyc = 1; cyc <= 100 && doneCycle == 0; cyc++) begin
            @(negedge clock);
            if (bus.done) begin
                doneCycle = cyc;
                if (bus.stall) stallGap = 1'b1;
            end else if (bus.stall) begin
                if (stallCycles != cyc - 1) stallGap = 1'b1;
                stallCycles++;
            end
            @(posedge clock); #1;
            bus.rs_data = $urandom; bus.rt_data = $urandom;
        end
        bus.is_div = 1'b0;
    endtask

    task automatic test_reset();
        bus.is_div = 1'b1; bus.mf = 1'b0; bus.lo_or_hi = 1'b1;
        bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", bus.stall); end
        checks++;
        if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            failures++; $display("FAIL reset_done: got done=%b dz=%b required 0 0", bus.done, bus.div_by_zero);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.hilo_out !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h required 0", bus.hilo_out); end
        bus.lo_or_hi = 1'b0; #1;
        checks++;
        if (bus.hilo_out !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h required 0", bus.hilo_out); end
        @(posedge clock); #1;
        reset = 1'b0; bus.is_div = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int s, d; bit g;
        do_div(32'd100, 32'd7, s, d, g);
        checks++;
        if (s != 34 || g) begin failures++; $display("FAIL basic_stall: got %0d gap=%0b required 34 gap=0", s, g); end
        checks++;
        if (d != 35) begin failures++; $display("FAIL basic_done_cycle: got %0d required 35", d); end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b required 0", bus.done); end
        @(posedge clock); #1;
    endtask

    task automatic test_signs();
        int s, d; bit g;
        do_div(32'hFFFF_FFF9, 32'd2, s, d, g);
        checks++;
        if (s != 34 || d != 35 || g) begin failures++; $display("FAIL neg_dividend_timing: got stall=%0d done=%0d required 34 35", s, d); end
        do_div(32'd7, 32'hFFFF_FFFE, s, d, g);
        checks++;
        if (s != 34 || d != 35 || g) begin failures++; $display("FAIL neg_divisor_timing: got stall=%0d done=%0d required 34 35", s, d); end
    endtask

    task automatic test_overflow();
        int s, d; bit g;
        do_div(32'h8000_0000, 32'hFFFF_FFFF, s, d, g);
        checks++;
        if (s != 34 || d != 35 || g) begin failures++; $display("FAIL overflow_timing: got stall=%0d done=%0d required 34 35", s, d); end
    endtask

    task automatic test_div_zero();
        int s, d; bit g;
        do_div(32'd5, 32'd0, s, d, g);
        checks++;
        if (s != 2 || g) begin failures++; $display("FAIL dz_stall: got %0d required 2", s); end
        checks++;
        if (d != 3) begin failures++; $display("FAIL dz_done_cycle: got %0d required 3", d); end
    endtask

    task automatic test_mid_reset();
        int s, d, doneSeen; bit g;
        bus.rs_data = 32'd100; bus.rt_data = 32'd7; bus.is_div = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1; bus.is_div = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL midreset_stall_in_reset: got %b required 0", bus.stall); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL midreset_stall: got %b required 0", bus.stall); end
        bus.lo_or_hi = 1'b1; #1;
        checks++;
        if (bus.hilo_out !== 32'd0) begin failures++; $display("FAIL midreset_lo: got %h required 0", bus.hilo_out); end
        bus.lo_or_hi = 1'b0; #1;
        checks++;
        if (bus.hilo_out !== 32'd0) begin failures++; $display("FAIL midreset_hi: got %h required 0", bus.hilo_out); end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.done) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin failures++; $display("FAIL midreset_no_done: got %0d pulses required 0", doneSeen); end
        // A fresh div timed from IDLE confirms the machine really returned there
        do_div(32'hFFFF_FFF0, 32'd0, s, d, g);
        checks++;
        if (s != 2 || d != 3) begin failures++; $display("FAIL midreset_idle: got stall=%0d done=%0d required 2 3", s, d); end
    endtask

    task automatic test_back_to_back();
        int done1, done2, stall35, stall36;
        done1 = 0; done2 = 0; stall35 = -1; stall36 = -1;
        sb.push_back(model(32'd9, 32'd3));
        sb.push_back(model(32'd9, 32'd3));
        bus.rs_data = 32'd9; bus.rt_data = 32'd3; bus.is_div = 1'b1;
        for (int cyc = 1; cyc <= 100 && done2 == 0; cyc++) begin
            @(negedge clock);
            if (cyc == 35) stall35 = int'(bus.stall);
            if (cyc == 36) stall36 = int'(bus.stall);
            if (bus.done) begin
                if (done1 == 0) done1 = cyc;
                else done2 = cyc;
            end
            @(posedge clock); #1;
        end
        bus.is_div = 1'b0;
        checks++;
        if (done1 != 35) begin failures++; $display("FAIL b2b_first_done: got %0d required 35", done1); end
        checks++;
        if (done2 - done1 != 35) begin failures++; $display("FAIL b2b_spacing: got %0d required 35", done2 - done1); end
        checks++;
        if (stall35 != 0 || stall36 != 1) begin
            failures++; $display("FAIL b2b_restart: got stall35=%0d stall36=%0d required 0 1", stall35, stall36);
        end
    endtask

    task automatic test_mf();
        bus.is_div = 1'b0; bus.mf = 1'b1; bus.lo_or_hi = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL mf_stall: got %b required 0", bus.stall); end
        checks++;
        if (bus.hilo_out !== 32'd3) begin failures++; $display("FAIL mf_lo: got %h required 3", bus.hilo_out); end
        bus.lo_or_hi = 1'b0; #1;
        checks++;
        if (bus.hilo_out !== 32'd0) begin failures++; $display("FAIL mf_hi: got %h required 0", bus.hilo_out); end
        @(posedge clock); #1;
        bus.mf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_mid_reset();
        test_back_to_back();
        test_mf();
        repeat (3) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
